if_stage: RTL and testbench

Instruction-fetch stage for the five-stage LoongArch core: generates the next PC, issues instruction fetches on the SRAM-like instruction interface, and delivers `{inst, pc}` to the decode stage. It consumes the decode stage's branch redirect bus, so it is the producer of the fetch-to-decode bus and the consumer of the branch bus. It allows at most one outstanding fetch and holds one returned instruction while decode stalls.

---
 rtl/if_stage.sv | 125 ++++++++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, one outstanding SRAM-like fetch, one-entry
// instruction buffer for decode stalls, and branch redirect with wrong-path data discard.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_pend_target_q, br_pend_target_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_leave;
  logic        fs_free;
  logic        accept;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // A fresh redirect beats a pending one, which beats sequential fetch.
  assign nextpc = br_taken  ? br_target :
                  br_pend_q ? br_pend_target_q :
                              fs_pc_q + 32'd4;

  assign fs_ready_go    = buf_valid_q | (outstanding_q & inst_sram_data_ok & ~discard_q);
  assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~br_taken;
  assign fs_to_ds_bus   = {(buf_valid_q ? inst_buf_q : inst_sram_rdata), fs_pc_q};
  assign fs_leave       = fs_to_ds_valid & ds_allowin;
  assign fs_free        = ~fs_valid_q | fs_leave | br_taken;

  // A returning response frees the single outstanding slot in the same cycle.
  assign inst_sram_req   = resetn & fs_free & (~outstanding_q | inst_sram_data_ok);
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  assign accept = inst_sram_req & inst_sram_addr_ok;

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    outstanding_d    = outstanding_q;
    discard_d        = discard_q;
    buf_valid_d      = buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;

    if (inst_sram_data_ok) begin
      outstanding_d = 1'b0;
      if (discard_q) discard_d = 1'b0;
    end
    if (inst_sram_data_ok & ~discard_q & fs_valid_q & ~fs_leave & ~br_taken) begin
      inst_buf_d  = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end
    if (fs_leave) begin
      fs_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
    end
    // Wrong-path flush: an in-flight fetch must have its data dropped on return.
    if (br_taken) begin
      fs_valid_d       = 1'b0;
      buf_valid_d      = 1'b0;
      if (outstanding_q & ~inst_sram_data_ok) discard_d = 1'b1;
      br_pend_d        = 1'b1;
      br_pend_target_d = br_target;
    end
    if (accept) begin
      fs_valid_d    = 1'b1;
      fs_pc_d       = nextpc;
      outstanding_d = 1'b1;
      buf_valid_d   = 1'b0;
      br_pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      outstanding_q    <= 1'b0;
      discard_q        <= 1'b0;
      buf_valid_q      <= 1'b0;
      inst_buf_q       <= 32'h0;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'h0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      outstanding_q    <= outstanding_d;
      discard_q        <= discard_d;
      buf_valid_q      <= buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: transaction-level fetch model checked every cycle, an in-order
// SRAM responder with programmable latency, and literal expectations per scenario.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a ^ 32'h0f0f_0000;
  endfunction

  // SRAM responder: in-order, each request answers mem_delay cycles after the next cycle.
  logic [31:0] mq_addr[$];
  int          mq_cnt[$];
  int          mem_delay = 0;

  // Fetch model: the IF slot (pc, held word), one in-flight fetch, and the next fetch address.
  logic        m_have, m_held, m_infl, m_drop;
  logic [31:0] m_pc, m_inst, m_next;

  logic        rec_req[64];
  logic [31:0] rec_addr[64];
  logic        rec_vld[64];
  logic [31:0] rec_pc[64];
  logic [31:0] rec_inst[64];
  int          cyc_n = 0;

  task automatic model_reset();
    m_have = 0; m_held = 0; m_infl = 0; m_drop = 0;
    m_pc = 0; m_inst = 0; m_next = RESET_PC;
    mq_addr.delete(); mq_cnt.delete();
  endtask

  task automatic cyc(input logic allow, input logic br, input logic [31:0] tgt, input logic aok);
    logic arriving, present, consumed, slot_free, can_req, dok;
    logic [31:0] e_addr, e_inst, rd;
    ds_allowin        = allow;
    br_bus            = {br, tgt};
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = resetn && mq_addr.size() > 0 && mq_cnt[0] == 0;
    inst_sram_rdata   = inst_sram_data_ok ? inst_of(mq_addr[0]) : 32'h0;
    dok = inst_sram_data_ok;
    rd  = inst_sram_rdata;
    @(negedge clk);
    chk("const_outs", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
        {1'b0, 2'b10, 4'b0000, 32'h0});
    if (!resetn) begin
      chk("rst_req", inst_sram_req, 1'b0);
      chk("rst_vld", fs_to_ds_valid, 1'b0);
      model_reset();
    end else begin
      arriving  = m_infl & dok & ~m_drop;
      present   = m_have & (m_held | arriving) & ~br;
      e_inst    = m_held ? m_inst : rd;
      consumed  = present & allow;
      slot_free = ~m_have | consumed | br;
      can_req   = slot_free & (~m_infl | dok);
      e_addr    = br ? tgt : m_next;
      chk("req", inst_sram_req, can_req);
      if (can_req) chk("addr", inst_sram_addr, e_addr);
      chk("valid", fs_to_ds_valid, present);
      if (present) chk("bus", fs_to_ds_bus, {e_inst, m_pc});
      if (can_req & aok) begin
        m_have = 1; m_held = 0; m_pc = e_addr; m_infl = 1; m_drop = 0;
        m_next = e_addr + 32'd4;
      end else begin
        if (dok) begin m_infl = 0; m_drop = 0; end
        if (arriving & m_have & ~consumed & ~br) begin m_held = 1; m_inst = rd; end
        if (consumed | br) begin m_have = 0; m_held = 0; end
        if (br) begin
          m_next = tgt;
          if (m_infl) m_drop = 1;
        end
      end
      if (dok) begin void'(mq_addr.pop_front()); void'(mq_cnt.pop_front()); end
      if (mq_cnt.size() > 0 && mq_cnt[0] > 0) mq_cnt[0] = mq_cnt[0] - 1;
      if (inst_sram_req & aok) begin mq_addr.push_back(inst_sram_addr); mq_cnt.push_back(mem_delay); end
    end
    if (cyc_n < 64) begin
      rec_req[cyc_n]  = inst_sram_req;
      rec_addr[cyc_n] = inst_sram_addr;
      rec_vld[cyc_n]  = fs_to_ds_valid;
      rec_pc[cyc_n]   = fs_to_ds_bus[31:0];
      rec_inst[cyc_n] = fs_to_ds_bus[63:32];
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation for recorded cycle c (relative to reset release).
  task automatic lit(input string n, input int c, input logic r, input logic [31:0] a,
                     input logic v, input logic [31:0] pc);
    chk({n, "_req"}, rec_req[c], r);
    if (r) chk({n, "_addr"}, rec_addr[c], a);
    chk({n, "_vld"}, rec_vld[c], v);
    if (v) chk({n, "_bus"}, {rec_inst[c], rec_pc[c]}, {inst_of(pc), pc});
  endtask

  // Called at posedge+1: asserts reset mid-cycle, holds it two cycles, releases.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("async_rst_req", inst_sram_req, 1'b0);
    chk("async_rst_vld", fs_to_ds_valid, 1'b0);
    mem_delay = 0;
    model_reset();
    repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    resetn = 1'b1;
    cyc_n  = 0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;

    // Streaming after reset release
    do_reset();
    repeat (6) cyc(1, 0, 0, 1);
    lit("s0", 0, 1, 32'h1c00_0000, 0, 0);
    lit("s1", 1, 1, 32'h1c00_0004, 1, 32'h1c00_0000);
    lit("s2", 2, 1, 32'h1c00_0008, 1, 32'h1c00_0004);
    lit("s3", 3, 1, 32'h1c00_000c, 1, 32'h1c00_0008);

    // Decode stall while data for 1c000010 returns
    do_reset();
    repeat (5) cyc(1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 1);
    lit("st4", 4, 1, 32'h1c00_0010, 1, 32'h1c00_000c);
    lit("st5", 5, 0, 0, 1, 32'h1c00_0010);
    lit("st6", 6, 0, 0, 1, 32'h1c00_0010);
    lit("st7", 7, 0, 0, 1, 32'h1c00_0010);
    lit("st8", 8, 1, 32'h1c00_0014, 1, 32'h1c00_0010);
    lit("st9", 9, 1, 32'h1c00_0018, 1, 32'h1c00_0014);

    // Branch while fetch of 1c000008 is outstanding with slow data
    do_reset();
    repeat (2) cyc(1, 0, 0, 1);
    mem_delay = 2;
    cyc(1, 0, 0, 1);
    mem_delay = 0;
    cyc(1, 1, 32'h1c00_0100, 1);
    repeat (4) cyc(1, 0, 0, 1);
    lit("bd2", 2, 1, 32'h1c00_0008, 1, 32'h1c00_0004);
    lit("bd3", 3, 0, 0, 0, 0);
    lit("bd4", 4, 0, 0, 0, 0);
    lit("bd5", 5, 1, 32'h1c00_0100, 0, 0);
    lit("bd6", 6, 1, 32'h1c00_0104, 1, 32'h1c00_0100);

    // Branch while addr_ok is low: redirect held pending
    do_reset();
    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h1c00_0100, 0);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 1);
    lit("bp1", 1, 1, 32'h1c00_0100, 0, 0);
    lit("bp2", 2, 1, 32'h1c00_0100, 0, 0);
    lit("bp3", 3, 1, 32'h1c00_0100, 0, 0);
    lit("bp4", 4, 1, 32'h1c00_0104, 1, 32'h1c00_0100);

    // Branch while the buffer holds 1c000020
    do_reset();
    repeat (9) cyc(1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h1c00_0100, 1);
    repeat (2) cyc(1, 0, 0, 1);
    lit("bb8", 8, 1, 32'h1c00_0020, 1, 32'h1c00_001c);
    lit("bb9", 9, 0, 0, 1, 32'h1c00_0020);
    lit("bb10", 10, 0, 0, 1, 32'h1c00_0020);
    lit("bb11", 11, 1, 32'h1c00_0100, 0, 0);
    lit("bb12", 12, 1, 32'h1c00_0104, 1, 32'h1c00_0100);

    // Asynchronous reset mid-stream with a fetch outstanding
    do_reset();
    repeat (3) cyc(1, 0, 0, 1);
    ds_allowin        = 1'b1;
    br_bus            = '0;
    inst_sram_addr_ok = 1'b1;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst_of(32'h1c00_0008);
    #1;
    chk("pre_rst_req", inst_sram_req, 1'b1);
    chk("pre_rst_vld", fs_to_ds_valid, 1'b1);
    do_reset();
    repeat (3) cyc(1, 0, 0, 1);
    lit("ar0", 0, 1, 32'h1c00_0000, 0, 0);
    lit("ar1", 1, 1, 32'h1c00_0004, 1, 32'h1c00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
